// File: rtl/rtc_tick_divider.sv
// Multi-channel programmable tick / clock-enable generator.
// Each channel counts down from its ratio and emits a one-cycle tick on every
// reload, plus a divided output that either toggles (50% duty) or pulses.
module rtc_tick_divider #(
  parameter int channels    = 2,
  parameter int cnt_width   = 16,
  parameter int default_div = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cfg_wen,
  input  logic [$clog2(channels):0]    cfg_chan,
  input  logic [cnt_width-1:0]         cfg_div,
  input  logic                         cfg_en,
  input  logic                         cfg_mode,
  input  logic                         sync_i,
  output logic [cnt_width+1:0]         cfg_rdata,
  output logic [channels-1:0]          tick_o,
  output logic [channels-1:0]          clk_o
);

  localparam int chan_w = $clog2(channels) + 1;
  localparam logic [cnt_width-1:0] reset_div = cnt_width'(default_div);

  // The ratio in force for the running period is implicit in cnt; reloads
  // always take div_shadow, so a mid-period write never truncates a period.
  logic [cnt_width-1:0] div_shadow  [channels];
  logic [cnt_width-1:0] cnt         [channels];
  logic [cnt_width-1:0] shadow_next [channels];
  logic [cnt_width-1:0] cnt_next    [channels];
  logic [channels-1:0]  en, mode;
  logic [channels-1:0]  en_next, mode_next, tick_next, clk_next;
  logic [channels-1:0]  hit, restart;

  // Next-state per channel: config write first, then sync, then counting.
  always_comb begin
    hit       = '0;
    restart   = '0;
    en_next   = en;
    mode_next = mode;
    tick_next = '0;
    clk_next  = '0;
    for (int unsigned i = 0; i < channels; i++) begin
      hit[i]         = cfg_wen && (cfg_chan == chan_w'(i));
      shadow_next[i] = hit[i] ? cfg_div : div_shadow[i];
      cnt_next[i]    = cnt[i];
      if (hit[i]) begin
        en_next[i]   = cfg_en;
        mode_next[i] = cfg_mode;
      end
      restart[i] = (hit[i] && ((cfg_en != en[i]) || (cfg_mode != mode[i])))
                   || (sync_i && en_next[i]);
      if (!en_next[i]) begin
        cnt_next[i] = shadow_next[i];
      end else if (restart[i]) begin
        cnt_next[i] = shadow_next[i];
      end else if (cnt[i] == '0) begin
        cnt_next[i]  = shadow_next[i];
        tick_next[i] = 1'b1;
        clk_next[i]  = mode[i] ? 1'b1 : ~clk_o[i];
      end else begin
        cnt_next[i] = cnt[i] - cnt_width'(1);
        clk_next[i] = mode[i] ? 1'b0 : clk_o[i];
      end
    end
  end

  // Channel state registers with asynchronous return to the default ratio.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < channels; i++) begin
        div_shadow[i] <= reset_div;
        cnt[i]        <= reset_div;
      end
      en     <= '1;
      mode   <= '0;
      tick_o <= '0;
      clk_o  <= '0;
    end else begin
      for (int unsigned i = 0; i < channels; i++) begin
        div_shadow[i] <= shadow_next[i];
        cnt[i]        <= cnt_next[i];
      end
      en     <= en_next;
      mode   <= mode_next;
      tick_o <= tick_next;
      clk_o  <= clk_next;
    end
  end

  // Readback of the addressed channel; out-of-range index reads zero.
  always_comb begin
    cfg_rdata = '0;
    for (int unsigned i = 0; i < channels; i++) begin
      if (cfg_chan == chan_w'(i)) begin
        cfg_rdata = {en[i], mode[i], div_shadow[i]};
      end
    end
  end

endmodule

// File: tb/tb_rtc_tick_divider.sv
// Bench for rtc_tick_divider: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a schedule-based model.
module tb_rtc_tick_divider;
  localparam int CH  = 2;
  localparam int W   = 16;
  localparam int DEF = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_wen = 1'b0;
  logic [1:0]    cfg_chan = '0;
  logic [W-1:0]  cfg_div = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_mode = 1'b0;
  logic          sync_i = 1'b0;
  logic [W+1:0]  cfg_rdata;
  logic [CH-1:0] tick_o;
  logic [CH-1:0] clk_o;

  int checks = 0;
  int failures = 0;
  int rel = 0;

  rtc_tick_divider #(.channels(CH), .cnt_width(W), .default_div(DEF)) dut (
    .clock(clock), .reset(reset), .cfg_wen(cfg_wen), .cfg_chan(cfg_chan),
    .cfg_div(cfg_div), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .sync_i(sync_i),
    .cfg_rdata(cfg_rdata), .tick_o(tick_o), .clk_o(clk_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, rel);
    end
  endtask

  // Model: each channel tracks the absolute edge number of its next tick.
  longint      ecount = 0;
  int unsigned m_shadow [CH] = '{default: DEF};
  bit          m_en     [CH] = '{default: 1'b1};
  bit          m_mode   [CH] = '{default: 1'b0};
  longint      m_next   [CH] = '{default: DEF + 1};
  int          m_ntick  [CH] = '{default: 0};
  bit          m_tick   [CH] = '{default: 1'b0};
  bit          m_clk    [CH] = '{default: 1'b0};

  always @(posedge clock or negedge reset) begin : model
    longint ec;
    longint nx;
    int unsigned sh;
    int nt;
    bit e, md, rs, tk, ck;
    if (!reset) begin
      for (int i = 0; i < CH; i++) begin
        m_shadow[i] <= DEF;
        m_en[i]     <= 1'b1;
        m_mode[i]   <= 1'b0;
        m_next[i]   <= ecount + DEF + 1;
        m_ntick[i]  <= 0;
        m_tick[i]   <= 1'b0;
        m_clk[i]    <= 1'b0;
      end
    end else begin
      ec = ecount + 1;
      ecount <= ec;
      for (int i = 0; i < CH; i++) begin
        sh = m_shadow[i]; e = m_en[i]; md = m_mode[i];
        nx = m_next[i]; nt = m_ntick[i];
        rs = 1'b0; tk = 1'b0; ck = 1'b0;
        if (cfg_wen && (int'(cfg_chan) == i)) begin
          sh = cfg_div;
          if (cfg_en != e || cfg_mode != md) begin
            e = cfg_en; md = cfg_mode; rs = 1'b1;
          end
        end
        if (sync_i && e) rs = 1'b1;
        if (e) begin
          if (rs) begin
            nx = ec + sh + 1;
            nt = 0;
          end else if (ec == nx) begin
            tk = 1'b1;
            nt++;
            nx = ec + sh + 1;
            ck = md ? 1'b1 : nt[0];
          end else begin
            ck = md ? 1'b0 : nt[0];
          end
        end
        m_shadow[i] <= sh; m_en[i] <= e; m_mode[i] <= md;
        m_next[i] <= nx; m_ntick[i] <= nt; m_tick[i] <= tk; m_clk[i] <= ck;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin : compare
    logic [CH-1:0] et, eclk;
    logic [W+1:0]  er;
    int c;
    for (int i = 0; i < CH; i++) begin
      et[i] = m_tick[i];
      eclk[i] = m_clk[i];
    end
    c = int'(cfg_chan);
    er = '0;
    if (c < CH) er = {m_en[c], m_mode[c], m_shadow[c][W-1:0]};
    check("model_tick", 64'(tick_o), 64'(et));
    check("model_clk", 64'(clk_o), 64'(eclk));
    check("model_rdata", 64'(cfg_rdata), 64'(er));
  end

  task automatic tick_edge();
    @(posedge clock);
    #2;
    rel++;
  endtask

  task automatic write(input int ch, input int div, input bit en, input bit md, input bit sy);
    cfg_chan = 2'(ch); cfg_div = W'(div); cfg_en = en; cfg_mode = md;
    cfg_wen = 1'b1; sync_i = sy;
    tick_edge();
    cfg_wen = 1'b0; sync_i = 1'b0;
  endtask

  initial begin
    bit exp_t;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;

    // Defaults: ticks on edges 5, 10, 15; toggle output period 10.
    for (int k = 1; k <= 15; k++) begin
      tick_edge();
      check("t1_tick0", 64'(tick_o[0]), 64'(k % 5 == 0));
      check("t1_clk0", 64'(clk_o[0]), 64'((k / 5) % 2));
    end

    // Mid-count ratio change on ch1 completes current period first.
    write(1, 9, 1'b1, 1'b0, 1'b0);
    for (int k = 17; k <= 41; k++) begin
      tick_edge();
      check("t2_tick1", 64'(tick_o[1]), 64'(k == 20 || k == 30 || k == 40));
      check("t2_tick0", 64'(tick_o[0]), 64'(k % 5 == 0));
    end

    // Pulse mode div=2 on ch0.
    write(0, 2, 1'b1, 1'b1, 1'b0);
    check("t3_clk_restart", 64'(clk_o[0]), 64'(0));
    for (int j = 1; j <= 9; j++) begin
      tick_edge();
      exp_t = (j % 3 == 0);
      check("t3_tick0", 64'(tick_o[0]), 64'(exp_t));
      check("t3_clk0", 64'(clk_o[0]), 64'(exp_t));
    end

    // div=0 toggle on ch1: adopted at reload on edge 60, then every cycle.
    write(1, 0, 1'b1, 1'b0, 1'b0);
    repeat (12) tick_edge();
    for (int j = 0; j < 6; j++) begin
      tick_edge();
      check("t4_tick_held", 64'(tick_o[1]), 64'(1));
      check("t4_clk_flip", 64'(clk_o[1]), 64'(rel % 2));
    end
    // div=0 pulse: clk held high.
    write(1, 0, 1'b1, 1'b1, 1'b0);
    check("t4_pulse_restart", 64'(clk_o[1]), 64'(0));
    for (int j = 0; j < 5; j++) begin
      tick_edge();
      check("t4_pulse_tick", 64'(tick_o[1]), 64'(1));
      check("t4_pulse_clk", 64'(clk_o[1]), 64'(1));
    end

    // Different phases at div=4, then sync aligns them.
    write(0, 4, 1'b1, 1'b0, 1'b0);
    repeat (2) tick_edge();
    write(1, 4, 1'b1, 1'b0, 1'b0);
    repeat (3) tick_edge();
    sync_i = 1'b1;
    tick_edge();
    sync_i = 1'b0;
    check("t5_sync_tick", 64'(tick_o), 64'(0));
    for (int j = 1; j <= 5; j++) begin
      tick_edge();
      check("t5_aligned", 64'(tick_o), (j == 5) ? 64'(3) : 64'(0));
    end
    // Sync together with a write of div=7 on ch0.
    write(0, 7, 1'b1, 1'b0, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      tick_edge();
      check("t5_div7", 64'(tick_o[0]), 64'(j == 8 || j == 16));
      check("t5_ch1", 64'(tick_o[1]), 64'(j % 5 == 0));
    end

    // Out-of-range channel write is ignored and reads zero.
    cfg_chan = 2'd2; cfg_div = W'(3); cfg_en = 1'b0; cfg_mode = 1'b1; cfg_wen = 1'b1;
    #1;
    check("t6_rdata_oor", 64'(cfg_rdata), 64'(0));
    tick_edge();
    cfg_wen = 1'b0;
    cfg_chan = 2'd0;
    #1;
    check("t6_rdata_ch0", 64'(cfg_rdata), 64'h20007);
    cfg_chan = 2'd1;
    #1;
    check("t6_rdata_ch1", 64'(cfg_rdata), 64'h20004);

    // Disable ch1.
    write(1, 4, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      check("t6_dis_tick", 64'(tick_o[1]), 64'(0));
      check("t6_dis_clk", 64'(clk_o[1]), 64'(0));
      tick_edge();
    end

    // Asynchronous reset mid-count, then a full default count.
    tick_edge();
    reset = 1'b0;
    #1;
    check("t6_rst_tick", 64'(tick_o), 64'(0));
    check("t6_rst_clk", 64'(clk_o), 64'(0));
    cfg_chan = 2'd0;
    #1;
    check("t6_rst_rdata", 64'(cfg_rdata), 64'h20004);
    tick_edge();
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick_edge();
      check("t6_restart", 64'(tick_o), (k % 5 == 0) ? 64'(3) : 64'(0));
    end

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      if (reset && $urandom_range(0, 999) < 3) begin
        reset = 1'b0;
        cfg_wen = 1'b0; sync_i = 1'b0;
      end else begin
        reset = 1'b1;
        cfg_wen  = ($urandom_range(0, 5) == 0);
        cfg_chan = 2'($urandom_range(0, 3));
        cfg_div  = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 20))
                                                 : W'($urandom_range(0, 9));
        cfg_en   = ($urandom_range(0, 7) != 0);
        cfg_mode = 1'($urandom_range(0, 1));
        sync_i   = ($urandom_range(0, 24) == 0);
      end
      tick_edge();
    end
    reset = 1'b1; cfg_wen = 1'b0; sync_i = 1'b0;
    repeat (3) tick_edge();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
